// File: rtl/seg7_scan_ctrl_if.sv
// Bundle between the scan controller, its shared hex decoder and the load side.
// master: drives value/load/enable and the decoder return; slave: the controller.
interface seg7_scan_ctrl_if #(
   parameter int NDIGIT = 4
);
   logic                  i_en;
   logic                  i_load;
   logic [4*NDIGIT-1:0]   i_value;
   logic [NDIGIT-1:0]     i_dp;
   logic                  i_lz;
   logic [3:0]            o_num;
   logic [6:0]            i_seg7;
   logic [6:0]            o_seg7;
   logic [NDIGIT-1:0]     o_an;
   logic                  o_dp;
   logic                  o_frame;
   logic                  o_pending;

   modport master (
      output i_en, i_load, i_value, i_dp, i_lz, i_seg7,
      input  o_num, o_seg7, o_an, o_dp, o_frame, o_pending
   );

   modport slave (
      input  i_en, i_load, i_value, i_dp, i_lz, i_seg7,
      output o_num, o_seg7, o_an, o_dp, o_frame, o_pending
   );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-seg scanner: SHOW/BLANK per digit, double buffered.
// Ports: i_clk, i_reset (sync, active-high), bus (seg7_scan_ctrl_if.slave).
module seg7_scan_ctrl #(
   parameter int NDIGIT = 4,
   parameter int DIV    = 50000,
   parameter int BLANK  = 500
) (
   input  logic i_clk,
   input  logic i_reset,
   seg7_scan_ctrl_if.slave bus
);

   localparam int CMAX = (DIV > BLANK) ? DIV : BLANK;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int IW   = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;
   localparam int VW   = 4 * NDIGIT;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHOW,
      ST_BLANK
   } state_t;

   state_t            state;
   state_t            nstate;
   logic [IW-1:0]     idx;
   logic [IW-1:0]     nidx;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     ncnt;
   logic [VW-1:0]     act;
   logic [VW-1:0]     nact;
   logic [VW-1:0]     shd;
   logic [NDIGIT-1:0] act_dp;
   logic [NDIGIT-1:0] nact_dp;
   logic [NDIGIT-1:0] shd_dp;
   logic              pend;
   logic              commit;
   logic              last_dig;
   logic [VW-1:0]     upper;
   logic              nshow;

   logic [3:0]        num_q;
   logic [NDIGIT-1:0] an_q;
   logic              dp_q;
   logic              show_q;
   logic              frame_q;

   // Next state is computed once and the registered outputs are
   // derived from it, so outputs change on the same edge as state.
   always_comb begin
      nstate   = state;
      nidx     = idx;
      ncnt     = cnt + CW'(1);
      commit   = 1'b0;
      last_dig = (idx == IW'(NDIGIT - 1));
      if (!bus.i_en) begin
         nstate = ST_IDLE;
         nidx   = '0;
         ncnt   = '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               nstate = ST_SHOW;
               nidx   = '0;
               ncnt   = '0;
               commit = pend;
            end
            ST_SHOW: begin
               if (cnt == CW'(DIV - 1)) begin
                  nstate = ST_BLANK;
                  ncnt   = '0;
               end
            end
            ST_BLANK: begin
               if (cnt == CW'(BLANK - 1)) begin
                  nstate = ST_SHOW;
                  ncnt   = '0;
                  nidx   = last_dig ? '0 : idx + IW'(1);
                  commit = pend & last_dig;
               end
            end
            default: begin
               nstate = ST_IDLE;
               nidx   = '0;
               ncnt   = '0;
            end
         endcase
      end
      nact    = commit ? shd : act;
      nact_dp = commit ? shd_dp : act_dp;
      // Nibbles nidx..NDIGIT-1 shifted down; zero means this digit
      // and everything above it are leading zeros.
      upper   = nact >> {nidx, 2'b00};
      nshow   = (nstate == ST_SHOW) &&
                !(bus.i_lz && (nidx != '0) && (upper == '0));
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state   <= ST_IDLE;
         idx     <= '0;
         cnt     <= '0;
         act     <= '0;
         act_dp  <= '0;
         shd     <= '0;
         shd_dp  <= '0;
         pend    <= 1'b0;
         num_q   <= 4'h0;
         an_q    <= '1;
         dp_q    <= 1'b1;
         show_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         state  <= nstate;
         idx    <= nidx;
         cnt    <= ncnt;
         act    <= nact;
         act_dp <= nact_dp;
         if (bus.i_load) begin
            shd    <= bus.i_value;
            shd_dp <= bus.i_dp;
         end
         // A load on the commit edge re-arms pending for the new value.
         pend    <= bus.i_load | (pend & ~commit);
         num_q   <= (nstate == ST_IDLE) ? 4'h0 : upper[3:0];
         an_q    <= nshow ? ~(NDIGIT'(1) << nidx) : '1;
         dp_q    <= nshow ? ~nact_dp[nidx] : 1'b1;
         show_q  <= nshow;
         frame_q <= (nstate == ST_BLANK) &&
                    (nidx == IW'(NDIGIT - 1)) &&
                    (ncnt == CW'(BLANK - 1));
      end
   end

   assign bus.o_num     = num_q;
   assign bus.o_an      = an_q;
   assign bus.o_dp      = dp_q;
   assign bus.o_frame   = frame_q;
   assign bus.o_pending = pend;
   assign bus.o_seg7    = show_q ? bus.i_seg7 : 7'h7F;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios then random stimulus,
// every cycle checked against a frame-position reference model.
module tb_seg7_scan_ctrl;

   localparam int N  = 4;
   localparam int DV = 4;
   localparam int BK = 2;
   localparam int SL = DV + BK;
   localparam int FR = N * SL;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   seg7_scan_ctrl_if #(.NDIGIT(N)) bus ();

   function automatic logic [6:0] dec(input logic [3:0] n);
      case (n)
         4'h0: dec = 7'h40;
         4'h1: dec = 7'h79;
         4'h2: dec = 7'h24;
         4'h3: dec = 7'h30;
         4'h4: dec = 7'h19;
         4'h5: dec = 7'h12;
         4'h6: dec = 7'h02;
         4'h7: dec = 7'h78;
         4'h8: dec = 7'h00;
         4'h9: dec = 7'h10;
         4'hA: dec = 7'h08;
         4'hB: dec = 7'h03;
         4'hC: dec = 7'h46;
         4'hD: dec = 7'h21;
         4'hE: dec = 7'h06;
         default: dec = 7'h0E;
      endcase
   endfunction

   assign bus.i_seg7 = dec(bus.o_num);

   seg7_scan_ctrl #(
      .NDIGIT(N),
      .DIV   (DV),
      .BLANK (BK)
   ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus)
   );

   // Reference state: run = cycles since scanning started (-1 = dark).
   int          run;
   logic [15:0] m_act;
   logic [15:0] m_sh;
   logic [3:0]  m_adp;
   logic [3:0]  m_sdp;
   logic        m_pend;
   int          n_cmp;
   int          n_bad;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s obs=%0h exp=%0h run=%0d", tag, obs, exp, run);
      end
   endtask

   task automatic step();
      logic        cm;
      logic        lz;
      logic        lit;
      int          p;
      int          slot;
      int          w;
      logic [15:0] hi;
      logic [3:0]  nib;
      logic [3:0]  e_an;
      logic        e_dp;
      @(posedge clk);
      lz = bus.i_lz;
      if (rst) begin
         run    = -1;
         m_act  = '0;
         m_adp  = '0;
         m_sh   = '0;
         m_sdp  = '0;
         m_pend = 1'b0;
      end else begin
         run = bus.i_en ? run + 1 : -1;
         cm  = bus.i_en && m_pend && (run % FR == 0);
         if (cm) begin
            m_act = m_sh;
            m_adp = m_sdp;
         end
         if (bus.i_load) begin
            m_sh   = bus.i_value;
            m_sdp  = bus.i_dp;
            m_pend = 1'b1;
         end else if (cm) begin
            m_pend = 1'b0;
         end
      end
      #1;
      e_an = 4'hF;
      e_dp = 1'b1;
      nib  = 4'h0;
      lit  = 1'b0;
      if (run >= 0) begin
         p    = run % FR;
         slot = p / SL;
         w    = p % SL;
         hi   = m_act >> (4 * slot);
         nib  = hi[3:0];
         lit  = (w < DV) && !(lz && slot > 0 && hi == 16'h0);
         if (lit) begin
            e_an[slot] = 1'b0;
            e_dp       = ~m_adp[slot];
         end
      end
      check("num",     32'(bus.o_num),     32'(nib));
      check("an",      32'(bus.o_an),      32'(e_an));
      check("dp",      32'(bus.o_dp),      32'(e_dp));
      check("seg7",    32'(bus.o_seg7),    32'(lit ? dec(nib) : 7'h7F));
      check("frame",   32'(bus.o_frame),
            32'(run >= 0 && (run % FR) == FR - 1));
      check("pending", 32'(bus.o_pending), 32'(m_pend));
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      bus.i_value = v;
      bus.i_dp    = d;
      bus.i_load  = 1'b1;
      step();
      bus.i_load  = 1'b0;
   endtask

   task automatic goto_pos(input int pos);
      for (int i = 0; i < 2 * FR && (run % FR) != pos; i++) step();
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      run         = -1;
      m_act       = '0;
      m_sh        = '0;
      m_adp       = '0;
      m_sdp       = '0;
      m_pend      = 1'b0;
      bus.i_en    = 1'b0;
      bus.i_load  = 1'b0;
      bus.i_value = '0;
      bus.i_dp    = '0;
      bus.i_lz    = 1'b0;

      // reset state
      repeat (2) step();
      rst = 1'b0;
      step();

      // 1234, load in IDLE, then two full frames
      do_load(16'h1234, 4'b0101);
      bus.i_en = 1'b1;
      repeat (2 * FR + 2) step();

      // leading-zero suppression on, then off
      bus.i_lz = 1'b1;
      do_load(16'h00A5, 4'b0011);
      repeat (2 * FR) step();
      bus.i_lz = 1'b0;
      repeat (FR) step();

      // load mid-frame at digit 2
      goto_pos(2 * SL);
      do_load(16'h1111, 4'b1000);
      repeat (2 * FR) step();

      // new load exactly on the commit edge
      do_load(16'h1234, 4'b0000);
      goto_pos(FR - 1);
      do_load(16'hBEEF, 4'b1111);
      repeat (2 * FR) step();

      // drop enable during SHOW of digit 2
      goto_pos(2 * SL + 1);
      bus.i_en = 1'b0;
      repeat (3) step();
      bus.i_en = 1'b1;
      repeat (FR + 3) step();

      // reset during BLANK with a pending load
      goto_pos(SL + DV);
      do_load(16'h4321, 4'b0110);
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (FR + 2) step();

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         bus.i_en    = ($urandom_range(0, 29) != 0);
         bus.i_load  = ($urandom_range(0, 9) == 0);
         bus.i_value = 16'($urandom);
         bus.i_dp    = 4'($urandom);
         bus.i_lz    = 1'($urandom);
         rst         = ($urandom_range(0, 249) == 0);
         step();
      end
      rst        = 1'b0;
      bus.i_load = 1'b0;
      repeat (2) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
